// File: rtl/median_window_sched.sv
// Controller for the median-filter datapath: drives a shared 3-input median unit
// from a 3-deep sliding window and returns one registered result per window step.
`timescale 1ns/1ps

module median_window_sched #(
  parameter int WIDTH       = 32,
  parameter int MED_LATENCY = 1,
  parameter int NUM_OUT     = 8533
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             m_rst_n,
  output logic [WIDTH-1:0] m_word0,
  output logic [WIDTH-1:0] m_word1,
  output logic [WIDTH-1:0] m_word2,
  input  logic [WIDTH-1:0] m_median_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done
);

  localparam int              CW        = $clog2(NUM_OUT + 1);
  localparam logic [3:0]      LAT_LAST  = 4'(MED_LATENCY - 1);
  localparam logic [CW-1:0]   NUM_OUT_C = CW'(NUM_OUT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST_LO = 3'd1,
    RST_HI = 3'd2,
    FILL   = 3'd3,
    RUN    = 3'd4,
    WAIT   = 3'd5,
    EMIT   = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t          state_r;
  logic [WIDTH-1:0] w0_r, w1_r, w2_r;
  logic [WIDTH-1:0] out_data_r;
  logic [CW-1:0]   res_cnt_r;
  logic [3:0]      lat_cnt_r;
  logic            fill_cnt_r;
  logic            in_ready_r;
  logic            m_rst_n_r;
  logic            out_valid_r;
  logic            busy_r;
  logic            done_r;

  logic            accept_s;
  logic            out_hs_s;
  logic [CW-1:0]   res_next_s;

  assign accept_s   = in_valid & in_ready_r;
  assign out_hs_s   = out_valid_r & out_ready;
  assign res_next_s = res_cnt_r + CW'(1'b1);

  // Sequencer: state, sliding window, counters and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      w0_r        <= {WIDTH{1'b0}};
      w1_r        <= {WIDTH{1'b0}};
      w2_r        <= {WIDTH{1'b0}};
      out_data_r  <= {WIDTH{1'b0}};
      res_cnt_r   <= {CW{1'b0}};
      lat_cnt_r   <= 4'd0;
      fill_cnt_r  <= 1'b0;
      in_ready_r  <= 1'b0;
      m_rst_n_r   <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          m_rst_n_r <= 1'b0;
          done_r    <= 1'b0;
          if (start) begin
            state_r    <= RST_LO;
            w0_r       <= {WIDTH{1'b0}};
            w1_r       <= {WIDTH{1'b0}};
            w2_r       <= {WIDTH{1'b0}};
            res_cnt_r  <= {CW{1'b0}};
            fill_cnt_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        RST_LO: begin
          m_rst_n_r <= 1'b1;
          state_r   <= RST_HI;
        end
        RST_HI: begin
          in_ready_r <= 1'b1;
          state_r    <= FILL;
        end
        FILL: begin
          if (accept_s) begin
            w2_r <= w1_r;
            w1_r <= w0_r;
            w0_r <= in_data;
            if (fill_cnt_r) begin
              state_r <= RUN;
            end else begin
              fill_cnt_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept_s) begin
            w2_r       <= w1_r;
            w1_r       <= w0_r;
            w0_r       <= in_data;
            lat_cnt_r  <= 4'd0;
            in_ready_r <= 1'b0;
            state_r    <= WAIT;
          end
        end
        WAIT: begin
          // The unit's result is only trustworthy on the final latency cycle.
          if (lat_cnt_r == LAT_LAST) begin
            out_data_r  <= m_median_word;
            out_valid_r <= 1'b1;
            state_r     <= EMIT;
          end else begin
            lat_cnt_r <= lat_cnt_r + 4'd1;
          end
        end
        EMIT: begin
          if (out_hs_s) begin
            res_cnt_r   <= res_next_s;
            out_valid_r <= 1'b0;
            if (res_next_s == NUM_OUT_C) begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              in_ready_r <= 1'b1;
              state_r    <= RUN;
            end
          end
        end
        DONE: begin
          done_r    <= 1'b0;
          busy_r    <= 1'b0;
          m_rst_n_r <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          m_rst_n_r   <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign m_rst_n   = m_rst_n_r;
  assign m_word0   = w0_r;
  assign m_word1   = w1_r;
  assign m_word2   = w2_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
